// File: rtl/meas_snapshot.sv
// Measurement snapshot for SPI readout.
// A raw chip select is synchronized and used to freeze the snapshot while the
// SPI master is reading. Samples arriving during a read are held in a 1-deep
// pending slot (newest wins, overrun flagged) and published when CS releases.
// A block averager runs independently of the freeze.
//
// state  | meaning
// IDLE   | CS inactive; samples go straight into the snapshot
// LOCKED | CS active; snapshot frozen, samples go to the pending slot
module meas_snapshot #(
  parameter int WIDTH    = 40,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk_48MHz,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             i_SPI_CS,
  output logic [WIDTH-1:0] snap_data,
  output logic [7:0]       snap_seq,
  output logic             snap_fresh,
  output logic [WIDTH-1:0] avg_out,
  output logic             overrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                    state;
  logic                      cs_m;
  logic                      cs_s;
  logic [7:0]                seq_cnt;
  logic [WIDTH-1:0]          pend_data;
  logic [7:0]                pend_seq;
  logic                      pend_full;
  logic [WIDTH+AVG_LOG2-1:0] acc;
  logic [WIDTH+AVG_LOG2-1:0] acc_sum;
  logic [AVG_LOG2-1:0]       smp_cnt;
  logic                      unlock_cyc;
  logic                      lock_first;

  // The state register holds last cycle's CS view, so comparing it with cs_s
  // identifies the first cycle of a lock and the first cycle after release.
  always_comb begin
    unlock_cyc = cs_s && (state == LOCKED);
    lock_first = !cs_s && (state == IDLE);
    acc_sum    = acc + {{AVG_LOG2{1'b0}}, count_in};
  end

  // Two-stage synchronizer for the asynchronous chip select; idles inactive.
  always_ff @(posedge clk_48MHz) begin
    if (rst) begin
      cs_m <= 1'b1;
      cs_s <= 1'b1;
    end else begin
      cs_m <= i_SPI_CS;
      cs_s <= cs_m;
    end
  end

  // Free-running sample tag; each sample carries the value before increment.
  always_ff @(posedge clk_48MHz) begin
    if (rst) begin
      seq_cnt <= 8'd0;
    end else if (count_valid) begin
      seq_cnt <= seq_cnt + 8'd1;
    end
  end

  // Lock FSM with snapshot, pending slot and sticky overrun.
  always_ff @(posedge clk_48MHz) begin
    if (rst) begin
      state      <= IDLE;
      snap_data  <= '0;
      snap_seq   <= 8'd0;
      snap_fresh <= 1'b0;
      pend_data  <= '0;
      pend_seq   <= 8'd0;
      pend_full  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= cs_s ? IDLE : LOCKED;
      if (cs_s) begin
        // A live sample on the release cycle is newer than the pending one.
        if (count_valid) begin
          snap_data  <= count_in;
          snap_seq   <= seq_cnt;
          snap_fresh <= 1'b1;
          pend_full  <= 1'b0;
        end else if (unlock_cyc && pend_full) begin
          snap_data  <= pend_data;
          snap_seq   <= pend_seq;
          snap_fresh <= 1'b1;
          pend_full  <= 1'b0;
        end
      end else begin
        if (lock_first) begin
          snap_fresh <= 1'b0;
        end
        if (count_valid) begin
          pend_data <= count_in;
          pend_seq  <= seq_cnt;
          pend_full <= 1'b1;
          if (pend_full) begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

  // Block averager; the extra AVG_LOG2 bits make overflow impossible.
  always_ff @(posedge clk_48MHz) begin
    if (rst) begin
      acc     <= '0;
      smp_cnt <= '0;
      avg_out <= '0;
    end else if (count_valid) begin
      if (smp_cnt == {AVG_LOG2{1'b1}}) begin
        avg_out <= acc_sum[WIDTH+AVG_LOG2-1:AVG_LOG2];
        acc     <= '0;
        smp_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        smp_cnt <= smp_cnt + 1'b1;
      end
    end
  end

endmodule
